// File: rtl/vga_scan_controller_if.sv
// Raster-timing bundle between the VGA scan controller, the figure renderer and the DAC pins.
// The controller is the master; it drives scan position, sync and colour, and receives rgb_in.
interface vga_scan_controller_if;
   logic [2:0] rgb_in;
   logic [9:0] HCount;
   logic [9:0] VCount;
   logic       pixel_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [2:0] rgb_out;
   logic       frame_start;

   modport master (
      input  rgb_in,
      output HCount, VCount, pixel_tick, hsync, vsync, video_on, rgb_out, frame_start
   );

   modport slave (
      output rgb_in,
      input  HCount, VCount, pixel_tick, hsync, vsync, video_on, rgb_out, frame_start
   );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA raster timing: clock divider, H/V scan counters and a registered output stage.
// The output stage lags HCount/VCount by one pixel period, so hsync, vsync and colour change together.
module vga_scan_controller #(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic                   clk,
   input  logic                   reset,
   vga_scan_controller_if.master  bus
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACTIVE = 10'(H_DISPLAY);
   localparam logic [9:0] V_ACTIVE = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_hCount;
   logic [9:0]       r_vCount;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_videoOn;
   logic [2:0]       r_rgbOut;
   logic             r_frameStart;

   logic w_tick;
   logic w_hLast;
   logic w_vLast;
   logic w_active;

   // Gating with reset keeps the tick low during reset even when CLK_DIV is 1.
   assign w_tick   = ~reset & (r_div == DIV_LAST);
   assign w_hLast  = (r_hCount == H_LAST);
   assign w_vLast  = (r_vCount == V_LAST);
   assign w_active = (r_hCount < H_ACTIVE) && (r_vCount < V_ACTIVE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
      end else if (r_div == DIV_LAST) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hCount     <= '0;
         r_vCount     <= '0;
         r_hsync      <= 1'b1;
         r_vsync      <= 1'b1;
         r_videoOn    <= 1'b0;
         r_rgbOut     <= 3'b000;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= w_tick & w_hLast & w_vLast;
         if (w_tick) begin
            if (w_hLast) begin
               r_hCount <= '0;
               r_vCount <= w_vLast ? '0 : r_vCount + 10'd1;
            end else begin
               r_hCount <= r_hCount + 10'd1;
            end
            // Decoded from the pre-increment position, hence the one-pixel lag on the pins.
            r_hsync   <= ~((r_hCount >= HS_START) && (r_hCount <= HS_END));
            r_vsync   <= ~((r_vCount >= VS_START) && (r_vCount <= VS_END));
            r_videoOn <= w_active;
            r_rgbOut  <= w_active ? bus.rgb_in : 3'b000;
         end
      end
   end

   assign bus.HCount      = r_hCount;
   assign bus.VCount      = r_vCount;
   assign bus.pixel_tick  = w_tick;
   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.video_on    = r_videoOn;
   assign bus.rgb_out     = r_rgbOut;
   assign bus.frame_start = r_frameStart;
endmodule
